adder_op_driver: RTL and testbench

// - Initiator side of the operand/sum interface: drives 7-bit operand pairs to the

---
 rtl/adder_op_driver.sv | 175 +++++++++++++++++
 tb/tb_adder_op_driver.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/adder_op_driver.sv
`default_nettype none
// ============================================================================
// Module  : adder_op_driver
// Brief   : Operand-pair initiator for the half-rate adder responder. Drives
//           NUM_OPS operand pairs, holds each for SETTLE cycles, then checks
//           the returned sum and keeps saturating pass/fail counts.
//           Optional feature macro: ADDER_DRV_LFSR_EN (LFSR operand source).
// Revision: 1.0 - initial release
// ============================================================================
module adder_op_driver #(
    parameter int OP_W    = 7,
    parameter int NUM_OPS = 16,
    parameter int SETTLE  = 4,
    parameter int CNT_W   = 8,
    localparam int IDX_W  = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2*OP_W-1:0] seed,
    output logic [OP_W-1:0]   op_a,
    output logic [OP_W-1:0]   op_b,
    output logic              op_valid,
    input  logic [OP_W:0]     result_in,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pass_cnt,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic              first_fail_valid,
    output logic [IDX_W-1:0]  first_fail_idx
);

    localparam int c_WAIT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [c_WAIT_W-1:0] c_WAIT_INIT = c_WAIT_W'(SETTLE - 1);
    localparam logic [IDX_W-1:0]    c_LAST_IDX  = IDX_W'(NUM_OPS - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_WAIT  = 2'd1;
    localparam logic [1:0] c_CHECK = 2'd2;

    logic [1:0]          r_state;
    logic [1:0]          w_state_nxt;
    logic [c_WAIT_W-1:0] r_wait;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    w_nxt_idx;
    logic [OP_W-1:0]     r_op_a;
    logic [OP_W-1:0]     r_op_b;
    logic [OP_W-1:0]     w_nxt_a;
    logic [OP_W-1:0]     w_nxt_b;
    logic [OP_W:0]       w_exp;
    logic                w_match;
    logic                w_last;
    logic                r_done;
    logic [CNT_W-1:0]    r_pass;
    logic [CNT_W-1:0]    r_fail;
    logic                r_ff_valid;
    logic [IDX_W-1:0]    r_ff_idx;

    assign w_last    = (r_idx == c_LAST_IDX);
    assign w_nxt_idx = (r_state == c_IDLE) ? '0 : r_idx + 1'b1;
    assign w_exp     = {1'b0, r_op_a} + {1'b0, r_op_b};
    assign w_match   = (result_in == w_exp);

`ifdef ADDER_DRV_LFSR_EN
    // 14-bit Fibonacci LFSR, taps 14,5,3,1; a zero seed would lock it up.
    logic [2*OP_W-1:0] r_lfsr;
    logic [2*OP_W-1:0] w_lfsr_seed;
    logic [2*OP_W-1:0] w_lfsr_step;
    logic [2*OP_W-1:0] w_lfsr_load;

    assign w_lfsr_seed = (seed == '0) ? {{(2*OP_W-1){1'b0}}, 1'b1} : seed;
    assign w_lfsr_step = {r_lfsr[2*OP_W-2:0],
                          r_lfsr[2*OP_W-1] ^ r_lfsr[4] ^ r_lfsr[2] ^ r_lfsr[0]};
    assign w_lfsr_load = (r_state == c_IDLE) ? w_lfsr_seed : w_lfsr_step;
    assign w_nxt_a     = w_lfsr_load[2*OP_W-1:OP_W];
    assign w_nxt_b     = w_lfsr_load[OP_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr <= '0;
        end else if ((r_state == c_IDLE && start) || r_state == c_CHECK) begin
            r_lfsr <= w_lfsr_load;
        end
    end
`else
    logic w_unused_seed;

    assign w_unused_seed = ^seed;
    assign w_nxt_a       = OP_W'(w_nxt_idx);
    assign w_nxt_b       = {w_nxt_a[OP_W-2:0], w_nxt_a[OP_W-1]};
`endif

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (start) w_state_nxt = c_WAIT;
            c_WAIT:  if (r_wait == '0) w_state_nxt = c_CHECK;
            c_CHECK: w_state_nxt = w_last ? c_IDLE : c_WAIT;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wait     <= '0;
            r_idx      <= '0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_done     <= 1'b0;
            r_pass     <= '0;
            r_fail     <= '0;
            r_ff_valid <= 1'b0;
            r_ff_idx   <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_pass     <= '0;
                        r_fail     <= '0;
                        r_done     <= 1'b0;
                        r_ff_valid <= 1'b0;
                        r_ff_idx   <= '0;
                        r_idx      <= w_nxt_idx;
                        r_op_a     <= w_nxt_a;
                        r_op_b     <= w_nxt_b;
                        r_wait     <= c_WAIT_INIT;
                    end
                end
                c_WAIT: begin
                    if (r_wait != '0) r_wait <= r_wait - 1'b1;
                end
                c_CHECK: begin
                    if (w_match) begin
                        if (~&r_pass) r_pass <= r_pass + 1'b1;
                    end else begin
                        if (~&r_fail) r_fail <= r_fail + 1'b1;
                        if (!r_ff_valid) begin
                            r_ff_valid <= 1'b1;
                            r_ff_idx   <= r_idx;
                        end
                    end
                    if (w_last) begin
                        r_done <= 1'b1;
                    end else begin
                        r_idx  <= w_nxt_idx;
                        r_op_a <= w_nxt_a;
                        r_op_b <= w_nxt_b;
                        r_wait <= c_WAIT_INIT;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy             = (r_state != c_IDLE);
    assign op_valid         = busy;
    assign op_a             = r_op_a;
    assign op_b             = r_op_b;
    assign done             = r_done;
    assign pass_cnt         = r_pass;
    assign fail_cnt         = r_fail;
    assign first_fail_valid = r_ff_valid;
    assign first_fail_idx   = r_ff_idx;

endmodule
`default_nettype wire

// File: tb/tb_adder_op_driver.sv
`default_nettype none
// ============================================================================
// Module  : tb_adder_op_driver
// Brief   : Randomized self-checking bench for adder_op_driver with a 2-cycle
//           responder model and a run-level behavioural reference.
// Revision: 1.0 - initial release
// ============================================================================
module tb_adder_op_driver;

    localparam int OP_W    = 7;
    localparam int NUM_OPS = 16;
    localparam int SETTLE  = 4;
    localparam int CNT_W   = 8;
    localparam int IDX_W   = 4;
    localparam int PER     = SETTLE + 1;
    localparam int RUN     = NUM_OPS * PER;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              start = 1'b0;
    logic [2*OP_W-1:0] seed = '0;
    logic [OP_W-1:0]   op_a;
    logic [OP_W-1:0]   op_b;
    logic              op_valid;
    logic [OP_W:0]     result_in;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  pass_cnt;
    logic [CNT_W-1:0]  fail_cnt;
    logic              first_fail_valid;
    logic [IDX_W-1:0]  first_fail_idx;

    adder_op_driver #(
        .OP_W(OP_W), .NUM_OPS(NUM_OPS), .SETTLE(SETTLE), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .seed(seed),
        .op_a(op_a), .op_b(op_b), .op_valid(op_valid), .result_in(result_in),
        .busy(busy), .done(done), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt),
        .first_fail_valid(first_fail_valid), .first_fail_idx(first_fail_idx)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference ----------------
    logic [NUM_OPS-1:0] fault_mask = '0;
    logic [7:0]         fault_xor  = 8'h01;
    logic [NUM_OPS-1:0] m_mask = '0;
    logic [13:0]        m_pairs [NUM_OPS];
    bit                 m_ever = 1'b0;
    int                 m_t    = 0;

    function automatic logic [13:0] lfsr_step(input logic [13:0] l);
        return {l[12:0], l[13] ^ l[4] ^ l[2] ^ l[0]};
    endfunction

    task automatic build_pairs(input logic [13:0] s);
        logic [13:0] l;
        logic [6:0]  a;
        l = (s == 14'd0) ? 14'd1 : s;
        for (int k = 0; k < NUM_OPS; k++) begin
`ifdef ADDER_DRV_LFSR_EN
            m_pairs[k] = l;
            l = lfsr_step(l);
`else
            a = 7'(k);
            m_pairs[k] = {a, a[5:0], a[6]};
`endif
        end
    endtask

    // Run position m_t counts clock edges since the accepted start edge.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_ever = 1'b0;
        end else if ((!m_ever || m_t >= RUN) && start) begin
            m_ever = 1'b1;
            m_t    = 0;
            m_mask = fault_mask;
            build_pairs(seed);
        end else if (m_ever && m_t < RUN) begin
            m_t++;
        end
    end

    // Responder: registered sum with two cycles of latency, corrupting chosen pairs.
    logic [7:0] resp1 = 8'h00;
    logic [7:0] resp2 = 8'h00;

    function automatic bit is_faulty(input logic [6:0] a, input logic [6:0] b);
        for (int i = 0; i < NUM_OPS; i++)
            if (m_mask[i] && m_pairs[i] == {a, b}) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        resp2 <= resp1;
        resp1 <= ({1'b0, op_a} + {1'b0, op_b}) ^ (is_faulty(op_a, op_b) ? fault_xor : 8'h00);
    end
    assign result_in = resp2;

    always @(negedge clk) begin
        int k, p, f, ffi;
        bit ffv, eb, ed;
        logic [13:0] pr;
        k = 0; p = 0; f = 0; ffi = 0; ffv = 1'b0; eb = 1'b0; ed = 1'b0; pr = '0;
        if (m_ever) begin
            k = m_t / PER;
            for (int i = 0; i < k; i++) begin
                if (m_mask[i]) begin
                    f++;
                    if (!ffv) begin ffv = 1'b1; ffi = i; end
                end else begin
                    p++;
                end
            end
            pr = m_pairs[(k > NUM_OPS - 1) ? NUM_OPS - 1 : k];
            eb = (m_t < RUN);
            ed = (m_t >= RUN);
        end
        check("busy", busy, eb);
        check("op_valid", op_valid, eb);
        check("done", done, ed);
        check("op_a", op_a, pr[13:7]);
        check("op_b", op_b, pr[6:0]);
        check("pass_cnt", pass_cnt, p);
        check("fail_cnt", fail_cnt, f);
        check("first_fail_valid", first_fail_valid, ffv);
        check("first_fail_idx", first_fail_idx, ffi);
    end

    // ---------------- stimulus ----------------
    logic [13:0] cap_seq [NUM_OPS];
    logic [13:0] seq0    [NUM_OPS];
    logic [7:0]  cap3r;

    // Caller must be at a negedge with the DUT idle; the next edge is the start edge.
    task automatic do_run(input logic [NUM_OPS-1:0] mask, input logic [13:0] s,
                          input int hold, input int pulse_at);
        int j;
        fault_mask = mask;
        fault_xor  = 8'($urandom_range(1, 255));
        seed       = s;
        start      = 1'b1;
        @(posedge clk);
        j = 0;
        @(negedge clk);
        while (!done && j < 4 * RUN) begin
            if (j % PER == 1 && j / PER < NUM_OPS) cap_seq[j / PER] = {op_a, op_b};
            if (j == 3 * PER + SETTLE) cap3r = result_in;
            start = (j < hold) || (j == pulse_at);
            @(negedge clk);
            j++;
        end
        start = (j < hold);
        check("done_time", j, RUN);
        check("run_pass", pass_cnt, NUM_OPS - $countones(mask));
        check("run_fail", fail_cnt, $countones(mask));
        check("run_ffv", first_fail_valid, mask != '0);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!done && n < 4 * RUN) begin
            @(negedge clk);
            n++;
        end
        check("wait_done", done, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 1'b0);
        check({tag, "_op_valid"}, op_valid, 1'b0);
        check({tag, "_done"}, done, 1'b0);
        check({tag, "_op_a"}, op_a, 7'h00);
        check({tag, "_op_b"}, op_b, 7'h00);
        check({tag, "_pass"}, pass_cnt, 8'h00);
        check({tag, "_fail"}, fail_cnt, 8'h00);
        check({tag, "_ffv"}, first_fail_valid, 1'b0);
        check({tag, "_ffi"}, first_fail_idx, 4'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NUM_OPS-1:0] rm;
        int lo;
        start = 1'b1;
        #1 rst = 1'b1;
        repeat (3) @(negedge clk);
        #1 check_all_zero("reset");

        // Release reset with start still high: run begins at the next edge.
        @(negedge clk);
        #2 rst = 1'b0;
        do_run('0, 14'h0000, 1, -1);
        check("clean_pass", pass_cnt, 8'd16);
        check("clean_fail", fail_cnt, 8'd0);
        check("clean_ffv", first_fail_valid, 1'b0);
        for (int k = 0; k < NUM_OPS; k++) seq0[k] = cap_seq[k];
`ifdef ADDER_DRV_LFSR_EN
        check("seed0_pair0", cap_seq[0], {7'h00, 7'h01});
        check("seed0_pair1", cap_seq[1], {7'h00, 7'h03});
`else
        check("idx3_ops", cap_seq[3], {7'h03, 7'h06});
        check("idx3_sum", cap3r, 8'h09);
        check("idx15_ops", cap_seq[15], {7'h0F, 7'h1E});
`endif

        repeat (3) @(negedge clk);
        do_run(16'h0020, 14'h0001, 1, -1);
        check("fault5_pass", pass_cnt, 8'd15);
        check("fault5_fail", fail_cnt, 8'd1);
        check("fault5_ffv", first_fail_valid, 1'b1);
        check("fault5_ffi", first_fail_idx, 4'd5);
        for (int k = 0; k < NUM_OPS; k++) check("seed0_vs_seed1", cap_seq[k], seq0[k]);

        // Extra start pulse mid-run must not disturb anything.
        @(negedge clk);
        do_run('0, 14'(($urandom)), 1, 20);
        check("busy_start_pass", pass_cnt, 8'd16);

        // Start held across done: new run on the first idle edge after done.
        do_run(16'h8001, 14'(($urandom)), RUN + 5, -1);
        @(negedge clk);
        check("b2b_busy", busy, 1'b1);
        check("b2b_done_cleared", done, 1'b0);
        start = 1'b0;
        wait_done();

        // Mid-run asynchronous reset.
        @(negedge clk);
        fault_mask = 16'h0004;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (29) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_all_zero("midrst");
        @(negedge clk);
        #2 rst = 1'b0;
        @(negedge clk);
        do_run(16'h0400, 14'(($urandom)), 2, -1);
        check("post_rst_ffi", first_fail_idx, 4'd10);

        // Randomized runs.
        for (int r = 0; r < 10; r++) begin
            rm = NUM_OPS'($urandom & $urandom);
            repeat ($urandom_range(0, 3)) @(negedge clk);
            do_run(rm, 14'(($urandom)), $urandom_range(0, 6), $urandom_range(2, 75));
            lo = 0;
            for (int i = NUM_OPS - 1; i >= 0; i--) if (rm[i]) lo = i;
            if (rm != '0) check("rand_ffi", first_fail_idx, lo);
        end

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
